// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller: converter FSM states,
// digit/width constants and the scan divider calculation.
package fnd_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;
  localparam int BCD_W      = 16;
  localparam int MAX_VAL    = 9999;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  function automatic int calc_div(input int clk_freq, input int scan_freq);
    return clk_freq / scan_freq;
  endfunction
endpackage

// File: rtl/fnd_scan_controller_if.sv
// Value handshake between a producer and the FND scan controller.
interface fnd_scan_controller_if;
  import fnd_pkg::*;

  logic             i_valid;
  logic [BIN_W-1:0] i_bin;
  logic             o_ready;
  logic             o_done;
  logic             o_overflow;

  modport master (output i_valid, i_bin, input o_ready, o_done, o_overflow);
  modport slave  (input i_valid, i_bin, output o_ready, o_done, o_overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, saturating input at 9999.
// done_o is high during the COMMIT cycle so the caller can latch bcd_o on that edge.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [BCD_W-1:0] bcd_o
);
  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [BCD_W-1:0] adj;

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    adj     = dabble_adjust(bcd_q);
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          ovf_d   = (bin_i > BIN_W'(MAX_VAL));
          bin_d   = ovf_d ? BIN_W'(MAX_VAL) : bin_i;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Adjust-then-shift; the 14th shift leaves the full BCD result in bcd_d.
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready_o    = (state_q == IDLE);
  assign done_o     = (state_q == COMMIT);
  assign overflow_o = ovf_q;
  assign bcd_o      = bcd_q;
endmodule

// File: rtl/fnd_scan_controller.sv
// Top level: converts accepted values to BCD, holds them in the display register,
// and time-multiplexes the four digits with optional leading-zero blanking.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int SCAN_FREQ = 1000,
  parameter bit LZ_BLANK  = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  fnd_scan_controller_if.slave   bus,
  input  logic                   i_display_on,
  output logic [1:0]             o_digitSelect,
  output logic [3:0]             o_value,
  output logic                   o_en
);
  localparam int DIV     = calc_div(CLK_FREQ, SCAN_FREQ);
  localparam int PRESC_W = $clog2(DIV);

  logic             commit;
  logic [BCD_W-1:0] conv_bcd;
  logic [BCD_W-1:0] disp_q;
  logic             done_q;
  logic [PRESC_W-1:0] presc_q;
  logic [1:0]       idx_q;
  logic             tick;
  logic [3:0]       blank;

  bin2bcd_seq u_conv (
    .clk_i      (i_clk),
    .rst_ni     (i_reset_n),
    .valid_i    (bus.i_valid),
    .bin_i      (bus.i_bin),
    .ready_o    (bus.o_ready),
    .done_o     (commit),
    .overflow_o (bus.o_overflow),
    .bcd_o      (conv_bcd)
  );

  assign tick = (presc_q == PRESC_W'(DIV - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      disp_q  <= '0;
      done_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      done_q  <= commit;
      if (commit) disp_q <= conv_bcd;
      presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
      if (tick) idx_q <= idx_q + 2'd1;
    end
  end

  always_comb begin
    blank = '0;
    if (LZ_BLANK) begin
      blank[3] = (disp_q[15:12] == 4'd0);
      blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
      blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
    end
  end

  assign bus.o_done    = done_q;
  assign o_digitSelect = idx_q;
  assign o_value       = disp_q[{idx_q, 2'b00} +: 4];
  assign o_en          = i_display_on && !blank[idx_q];
endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with DIV = 4; instance A blanks leading
// zeros, instance B shows all digits.
module tb_fnd_scan_controller;
  logic clk;
  logic rst_n;
  logic display_on;
  logic [1:0] sel_a, sel_b;
  logic [3:0] val_a, val_b;
  logic en_a, en_b;
  int n_tests;
  int n_fail;

  fnd_scan_controller_if bus_a ();
  fnd_scan_controller_if bus_b ();

  fnd_scan_controller #(.CLK_FREQ(100), .SCAN_FREQ(25), .LZ_BLANK(1'b1)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus_a), .i_display_on(display_on),
    .o_digitSelect(sel_a), .o_value(val_a), .o_en(en_a));

  fnd_scan_controller #(.CLK_FREQ(100), .SCAN_FREQ(25), .LZ_BLANK(1'b0)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus_b), .i_display_on(display_on),
    .o_digitSelect(sel_b), .o_value(val_b), .o_en(en_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic get_ready(input int s); return s ? bus_b.o_ready : bus_a.o_ready; endfunction
  function automatic logic get_done(input int s);  return s ? bus_b.o_done  : bus_a.o_done;  endfunction
  function automatic logic get_ovf(input int s);   return s ? bus_b.o_overflow : bus_a.o_overflow; endfunction
  function automatic logic [1:0] get_idx(input int s); return s ? sel_b : sel_a; endfunction
  function automatic logic [3:0] get_val(input int s); return s ? val_b : val_a; endfunction
  function automatic logic get_en(input int s);    return s ? en_b : en_a; endfunction

  task automatic accept(input int s, input logic [13:0] v);
    @(negedge clk);
    if (s != 0) begin bus_b.i_valid = 1'b1; bus_b.i_bin = v; end
    else begin bus_a.i_valid = 1'b1; bus_a.i_bin = v; end
    @(negedge clk);
    bus_a.i_valid = 1'b0;
    bus_b.i_valid = 1'b0;
  endtask

  // Returns cycles from the accept edge until o_done is seen; flags early ready.
  task automatic wait_done(input int s, input string name, output int n);
    int ready_seen;
    n = 0;
    ready_seen = 0;
    while (get_done(s) !== 1'b1 && n < 40) begin
      if (get_ready(s) !== 1'b0) ready_seen++;
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n !== 15) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles, expected 15", name, n);
    end
    n_tests++;
    if (ready_seen !== 0) begin
      n_fail++;
      $display("FAIL %s_busy_ready: ready high %0d times, expected 0", name, ready_seen);
    end
    n_tests++;
    if (get_ready(s) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_after: got %b, expected 1", name, get_ready(s));
    end
  endtask

  task automatic check_scan(input int s, input string name, input logic [15:0] exp_bcd,
                            input logic [3:0] exp_en);
    logic [1:0] ix, prev;
    int run;
    int first;
    prev  = get_idx(s);
    run   = 0;
    first = 1;
    for (int c = 0; c < 16; c++) begin
      ix = get_idx(s);
      n_tests++;
      if (get_val(s) !== exp_bcd[{ix, 2'b00} +: 4]) begin
        n_fail++;
        $display("FAIL %s_value idx%0d: got %0d, expected %0d", name, ix, get_val(s),
                 exp_bcd[{ix, 2'b00} +: 4]);
      end
      n_tests++;
      if (get_en(s) !== exp_en[ix]) begin
        n_fail++;
        $display("FAIL %s_en idx%0d: got %b, expected %b", name, ix, get_en(s), exp_en[ix]);
      end
      @(negedge clk);
      run++;
      ix = get_idx(s);
      if (ix !== prev) begin
        if (first == 0) begin
          n_tests++;
          if (run !== 4 || ix !== prev + 2'd1) begin
            n_fail++;
            $display("FAIL %s_advance: idx %0d->%0d after %0d clocks, expected +1 after 4",
                     name, prev, ix, run);
          end
        end
        first = 0;
        run   = 0;
        prev  = ix;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus_a.o_ready !== 1'b1 || bus_a.o_done !== 1'b0 || bus_a.o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/done/ovf got %b%b%b, expected 100",
               bus_a.o_ready, bus_a.o_done, bus_a.o_overflow);
    end
    n_tests++;
    if (sel_a !== 2'd0 || val_a !== 4'd0 || en_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_scan: sel/val/en got %0d/%0d/%b, expected 0/0/1", sel_a, val_a, en_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus_a.o_ready !== 1'b1 || val_a !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_release: ready/val got %b/%0d, expected 1/0", bus_a.o_ready, val_a);
    end
  endtask

  task automatic test_convert();
    int n;
    accept(0, 14'd1234);
    n_tests++;
    if (bus_a.o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL conv_ready_drop: got %b, expected 0", bus_a.o_ready);
    end
    wait_done(0, "conv1234", n);
    @(negedge clk);
    n_tests++;
    if (bus_a.o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL conv_done_pulse: got %b, expected 0 one cycle later", bus_a.o_done);
    end
    check_scan(0, "scan1234", 16'h1234, 4'b1111);
  endtask

  task automatic test_blanking();
    int n;
    accept(0, 14'd7);
    wait_done(0, "blank7", n);
    check_scan(0, "lz7", 16'h0007, 4'b0001);
    accept(1, 14'd7);
    wait_done(1, "noblank7", n);
    check_scan(1, "nolz7", 16'h0007, 4'b1111);
  endtask

  task automatic test_overflow();
    int n;
    accept(0, 14'd12345);
    n_tests++;
    if (bus_a.o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b, expected 1", bus_a.o_overflow);
    end
    wait_done(0, "ovf", n);
    check_scan(0, "scan9999", 16'h9999, 4'b1111);
    n_tests++;
    if (bus_a.o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b, expected 1", bus_a.o_overflow);
    end
    accept(0, 14'd42);
    n_tests++;
    if (bus_a.o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b, expected 0", bus_a.o_overflow);
    end
    wait_done(0, "v42", n);
    check_scan(0, "scan42", 16'h0042, 4'b0011);
  endtask

  task automatic test_back_to_back();
    int n;
    int extra;
    accept(0, 14'd5000);
    bus_a.i_valid = 1'b1;
    bus_a.i_bin   = 14'd1111;
    wait_done(0, "b2b", n);
    bus_a.i_valid = 1'b0;
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus_a.o_done !== 1'b0 || bus_a.o_ready !== 1'b1) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL b2b_ignored: %0d busy/done cycles, expected 0", extra);
    end
    check_scan(0, "scan5000", 16'h5000, 4'b1111);
  endtask

  task automatic test_reset_abort();
    int n;
    int dones;
    accept(0, 14'd9876);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus_a.o_ready !== 1'b1 || bus_a.o_done !== 1'b0 || sel_a !== 2'd0 || val_a !== 4'd0
        || en_a !== 1'b1 || bus_a.o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: rdy/done/sel/val/en/ovf got %b/%b/%0d/%0d/%b/%b, expected 1/0/0/0/1/0",
               bus_a.o_ready, bus_a.o_done, sel_a, val_a, en_a, bus_a.o_overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus_a.o_done !== 1'b0) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done pulses, expected 0", dones);
    end
    check_scan(0, "abort0000", 16'h0000, 4'b0001);
    accept(0, 14'd0);
    wait_done(0, "zero", n);
    check_scan(0, "scan0", 16'h0000, 4'b0001);
  endtask

  task automatic test_display_off();
    int n;
    @(negedge clk);
    display_on = 1'b0;
    accept(0, 14'd1234);
    wait_done(0, "off1234", n);
    check_scan(0, "off", 16'h1234, 4'b0000);
    display_on = 1'b1;
    @(negedge clk);
    n_tests++;
    if (en_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reenable: got %b, expected 1", en_a);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    display_on    = 1'b1;
    bus_a.i_valid = 1'b0;
    bus_a.i_bin   = '0;
    bus_b.i_valid = 1'b0;
    bus_b.i_bin   = '0;
    test_reset();
    test_convert();
    test_blanking();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_display_off();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
- Sequencing controller for the 4-digit BCD-to-FND display path.
- Accepts a 14-bit binary value over a valid/ready handshake and converts it to four BCD digits with a sequential double-dabble engine.
- Holds the converted digits in a display register.
- Time-multiplexes the digits by driving i_digitSelect, i_value and i_en of the BCDtoFND stage at a parameterised refresh rate, with optional leading-zero blanking.

Parameters:
- CLK_FREQ, 100_000_000, input clock frequency in Hz.
- SCAN_FREQ, 1000, digit-advance rate in Hz. DIV = CLK_FREQ/SCAN_FREQ; DIV must be ≥ 2.
- LZ_BLANK, 1, 1 = blank leading zero digits; 0 = always show all four digits.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_valid  in  1  new binary value offered.
- i_bin  in  14  binary value to display; values above 9999 saturate.
- o_ready  out  1  controller idle and able to accept a value.
- o_done  out  1  one-cycle pulse when the new digits are committed to the display.
- o_overflow  out  1  last accepted value was above 9999; sticky until the next accept.
- i_display_on  in  1  global display enable.
- o_digitSelect  out  2  digit index; 0 = ones, 3 = thousands.
- o_value  out  4  BCD digit for the selected index.
- o_en  out  1  enable for the selected digit.

Behaviour:
- Reset (async assert, sync release): state IDLE, display digits 0000, shift registers 0, prescaler 0, scan index 0, o_done 0, o_overflow 0.
  - After reset, o_ready = 1, o_digitSelect = 0, o_value = 0, o_en = i_display_on.
- Conversion FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: o_ready = 1. On i_valid && o_ready at edge E0:
    - latch min(i_bin, 9999);
    - set o_overflow = (i_bin > 9999);
    - clear the 16-bit BCD accumulator and the bit counter;
    - go to SHIFT.
  - SHIFT: o_ready = 0. Each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. Exactly 14 shifts occur, on E1..E14. After the 14th shift, go to COMMIT.
  - COMMIT: copy the accumulator to the display register on E15, pulse o_done high for the cycle after E15, then return to IDLE. o_ready is 1 again from the cycle after E15.
  - Latency: accept edge to display update is 15 clocks.
  - i_valid while o_ready = 0 is ignored and not queued.
- The display register changes only on COMMIT. The scan keeps showing the old digits during conversion, so there is no tearing.
- Scan path (independent of the FSM):
  - Prescaler counts 0..DIV-1 and wraps.
  - tick = (prescaler == DIV-1).
  - On tick, the scan index increments and wraps 3→0.
  - o_digitSelect = registered scan index.
  - o_value = display digit[index], combinational from registers.
- Blanking, only when LZ_BLANK = 1:
  - digit3 is blanked if d3 == 0;
  - digit2 is blanked if d3 == d2 == 0;
  - digit1 is blanked if d3 == d2 == d1 == 0;
  - digit0 is never blanked.
  - o_en = i_display_on && !blank[index].
- When i_display_on = 0, o_en = 0 but scanning and conversion continue.
- Reset mid-conversion aborts with no commit and returns to the reset state; the display returns to 0000.
- Commit coinciding with a tick: the tick uses the new digits from the following cycle. No special handling is needed.

Decomposition:
- Package fnd_pkg:
  - FSM state enum (IDLE, SHIFT, COMMIT);
  - NUM_DIGITS = 4, BIN_W = 14, BCD_W = 16, MAX_VAL = 9999;
  - function for the divider value.
- Sub-module bin2bcd_seq:
  - contains the double-dabble engine, FSM and counter;
  - exposes valid/ready in and a done/bcd out.
- Top level holds the display register, prescaler, scan index and blanking logic.

Test Plan:
- Use CLK_FREQ = 100 and SCAN_FREQ = 25 (DIV = 4) for all sims.
1. Reset then i_bin = 1234, i_valid for one cycle -> o_ready low for 15 cycles, o_done pulse 15 cycles after accept, digits {3,2,1,0} = {1,2,3,4}; scan shows idx 0 = 4, 1 = 3, 2 = 2, 3 = 1, index advancing every 4 clocks, all o_en = 1.
2. i_bin = 7, LZ_BLANK = 1 -> o_en = 1 only at idx 0 (o_value = 7); idx 1..3 have o_en = 0. Repeat with LZ_BLANK = 0 -> all four enabled, showing 0007.
3. i_bin = 12345 -> o_overflow = 1, display 9999. Next accept of 42 -> o_overflow = 0, display 0042 with idx 2 and 3 blanked.
4. i_bin = 5000 accepted, then i_valid with 1111 during SHIFT -> second value ignored; display becomes 5000 and stays there with no second o_done.
5. Accept 9876, assert i_reset_n = 0 at E7 for 2 cycles -> all outputs at reset values, display 0000, o_done never pulses; a new accept of 0 then gives a single lit digit 0 at idx 0.
6. i_display_on = 0 during a running scan -> o_en = 0 on all indices while o_digitSelect keeps cycling 0..3; re-enable restores o_en at the next cycle.
